time_keeper: RTL and testbench

- Time-of-day counter. Holds hours, minutes and seconds as BCD digit pairs.
- Advances once per 1 Hz strobe. Takes per-field adjust pulses from the three upstream button_pulse stages (hours, minutes, seconds).
- Drives the BCD digits consumed by the VGA digit renderer.
- Sits between the button pulse generators and the display path.

---
 rtl/clock_pkg.sv | 17 +
 rtl/bcd_counter_2d.sv | 50 +++++
 rtl/time_keeper.sv | 86 ++++++++
 tb/tb_time_keeper.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared widths, field limits and a BCD helper for the time-of-day counter.
package clock_pkg;
    localparam int HT_W = 2;
    localparam int MT_W = 3;
    localparam int ST_W = 3;
    localparam int U_W  = 4;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HRS_MAX_24 = 23;
    localparam int HRS_MAX_12 = 12;
    localparam int HRS_MIN_12 = 1;

    function automatic logic [7:0] bin2bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction
endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD field counter wrapping MAX -> MIN; 1-cycle registered update,
// combinational carry out and a registered wrap flag. No backpressure.
module bcd_counter_2d #(
    parameter int         TW  = 3,
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] RST = 8'h00
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          carry_en,
    output logic [TW-1:0] tens,
    output logic [3:0]    units,
    output logic          carry,
    output logic          wrap
);
    logic [TW-1:0] r_tens;
    logic [3:0]    r_units;
    logic          r_wrap;
    logic          w_at_max;

    assign w_at_max = ({r_tens, r_units} == MAX[TW+3:0]);
    assign carry    = inc & carry_en & w_at_max;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tens  <= RST[TW+3:4];
            r_units <= RST[3:0];
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= carry;
            if (inc) begin
                if (w_at_max) begin
                    r_tens  <= MIN[TW+3:4];
                    r_units <= MIN[3:0];
                end else if (r_units == 4'd9) begin
                    r_units <= 4'd0;
                    r_tens  <= r_tens + 1'b1;
                end else begin
                    r_units <= r_units + 4'd1;
                end
            end
        end
    end

    assign tens  = r_tens;
    assign units = r_units;
    assign wrap  = r_wrap;
endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss counter advanced by a 1 Hz tick or per-field adjust pulses.
// Outputs update 1 cycle after the input edge; no backpressure, every pulse is taken.
module time_keeper
    import clock_pkg::*;
#(
    parameter int HOURS_24  = 1,
    parameter int RESET_HRS = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sec_tick,
    input  logic            adj_hrs,
    input  logic            adj_min,
    input  logic            adj_sec,
    output logic [HT_W-1:0] hrs_t,
    output logic [U_W-1:0]  hrs_u,
    output logic [MT_W-1:0] min_t,
    output logic [U_W-1:0]  min_u,
    output logic [ST_W-1:0] sec_t,
    output logic [U_W-1:0]  sec_u,
    output logic            sec_strobe,
    output logic            day_wrap
);
    localparam logic [7:0] HRS_MAX_BCD = (HOURS_24 != 0) ? bin2bcd(HRS_MAX_24) : bin2bcd(HRS_MAX_12);
    localparam logic [7:0] HRS_MIN_BCD = (HOURS_24 != 0) ? 8'h00 : bin2bcd(HRS_MIN_12);
    localparam logic [7:0] HRS_RST_BCD = bin2bcd(RESET_HRS);

    logic w_adj_any;
    logic w_tick;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_hrs_carry;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_unused;
    logic r_sec_strobe;

    // Any adjust pulse swallows a coincident tick, so carries only exist in tick mode.
    assign w_adj_any = adj_hrs | adj_min | adj_sec;
    assign w_tick    = sec_tick & ~w_adj_any;

    bcd_counter_2d #(.TW(ST_W), .MAX(bin2bcd(SEC_MAX)), .MIN(8'h00), .RST(8'h00)) u_sec (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (adj_sec | w_tick),
        .carry_en (w_tick),
        .tens     (sec_t),
        .units    (sec_u),
        .carry    (w_sec_carry),
        .wrap     (w_sec_wrap)
    );

    bcd_counter_2d #(.TW(MT_W), .MAX(bin2bcd(MIN_MAX)), .MIN(8'h00), .RST(8'h00)) u_min (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (adj_min | w_sec_carry),
        .carry_en (w_tick),
        .tens     (min_t),
        .units    (min_u),
        .carry    (w_min_carry),
        .wrap     (w_min_wrap)
    );

    bcd_counter_2d #(.TW(HT_W), .MAX(HRS_MAX_BCD), .MIN(HRS_MIN_BCD), .RST(HRS_RST_BCD)) u_hrs (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (adj_hrs | w_min_carry),
        .carry_en (w_tick),
        .tens     (hrs_t),
        .units    (hrs_u),
        .carry    (w_hrs_carry),
        .wrap     (day_wrap)
    );

    assign w_unused = ^{w_sec_wrap, w_min_wrap, w_hrs_carry};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sec_strobe <= 1'b0;
        end else begin
            r_sec_strobe <= w_adj_any | sec_tick;
        end
    end

    assign sec_strobe = r_sec_strobe;
endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench: 24h and 12h instances share stimulus, a seconds/minutes/hours
// integer model predicts each cycle, and a monitor compares every output cycle.
module tb_time_keeper;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sec_tick = 1'b0;
    logic adj_hrs = 1'b0;
    logic adj_min = 1'b0;
    logic adj_sec = 1'b0;

    logic [1:0] a_ht, b_ht;
    logic [3:0] a_hu, b_hu, a_mu, b_mu, a_su, b_su;
    logic [2:0] a_mt, b_mt, a_st, b_st;
    logic       a_strb, b_strb, a_wrap, b_wrap;

    always #5 clk = ~clk;

    time_keeper #(.HOURS_24(1), .RESET_HRS(0)) dut24 (
        .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick),
        .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
        .hrs_t(a_ht), .hrs_u(a_hu), .min_t(a_mt), .min_u(a_mu),
        .sec_t(a_st), .sec_u(a_su), .sec_strobe(a_strb), .day_wrap(a_wrap)
    );

    time_keeper #(.HOURS_24(0), .RESET_HRS(12)) dut12 (
        .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick),
        .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
        .hrs_t(b_ht), .hrs_u(b_hu), .min_t(b_mt), .min_u(b_mu),
        .sec_t(b_st), .sec_u(b_su), .sec_strobe(b_strb), .day_wrap(b_wrap)
    );

    typedef struct {
        int h;
        int m;
        int s;
        bit strb;
        bit wrap;
    } mdl_t;

    mdl_t q24[$];
    mdl_t q12[$];
    mdl_t st24 = '{0, 0, 0, 1'b0, 1'b0};
    mdl_t st12 = '{12, 0, 0, 1'b0, 1'b0};

    int checks = 0;
    int failures = 0;
    int cnt_strb = 0;
    int cnt_wrap = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int next_h(input int h, input bit h24);
        if (h24) return (h + 1) % 24;
        return (h == 12) ? 1 : h + 1;
    endfunction

    // Reference: plain clock arithmetic on integer fields.
    task automatic model(inout mdl_t st, input bit h24, input int rst_h,
                         input bit rn, input bit tk, input bit ah, input bit am, input bit as);
        st.strb = 1'b0;
        st.wrap = 1'b0;
        if (!rn) begin
            st.h = rst_h;
            st.m = 0;
            st.s = 0;
        end else if (ah || am || as) begin
            if (as) st.s = (st.s + 1) % 60;
            if (am) st.m = (st.m + 1) % 60;
            if (ah) st.h = next_h(st.h, h24);
            st.strb = 1'b1;
        end else if (tk) begin
            st.strb = 1'b1;
            st.s++;
            if (st.s == 60) begin
                st.s = 0;
                st.m++;
                if (st.m == 60) begin
                    st.m = 0;
                    st.wrap = (st.h == (h24 ? 23 : 12));
                    st.h = next_h(st.h, h24);
                end
            end
        end
    endtask

    task automatic cycle(input bit rn, input bit tk, input bit ah, input bit am, input bit as);
        @(negedge clk);
        reset_n  = rn;
        sec_tick = tk;
        adj_hrs  = ah;
        adj_min  = am;
        adj_sec  = as;
        model(st24, 1'b1, 0, rn, tk, ah, am, as);
        model(st12, 1'b0, 12, rn, tk, ah, am, as);
        q24.push_back(st24);
        q12.push_back(st12);
    endtask

    task automatic preload(input int h, input int m, input int s);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++)
            cycle(1'b1, 1'b0, i < h, i < m, i < s);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic int hrs24();
        return int'(a_ht) * 10 + int'(a_hu);
    endfunction
    function automatic int min24();
        return int'(a_mt) * 10 + int'(a_mu);
    endfunction
    function automatic int sec24();
        return int'(a_st) * 10 + int'(a_su);
    endfunction

    initial begin
        mdl_t e;
        forever begin
            @(posedge clk);
            #1;
            if (a_strb) cnt_strb++;
            if (a_wrap) cnt_wrap++;
            if (q24.size() > 0) begin
                e = q24.pop_front();
                chk("d24_hrs", hrs24(), e.h);
                chk("d24_min", min24(), e.m);
                chk("d24_sec", sec24(), e.s);
                chk("d24_strobe", int'(a_strb), int'(e.strb));
                chk("d24_daywrap", int'(a_wrap), int'(e.wrap));
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                chk("d12_hrs", int'(b_ht) * 10 + int'(b_hu), e.h);
                chk("d12_min", int'(b_mt) * 10 + int'(b_mu), e.m);
                chk("d12_sec", int'(b_st) * 10 + int'(b_su), e.s);
                chk("d12_strobe", int'(b_strb), int'(e.strb));
                chk("d12_daywrap", int'(b_wrap), int'(e.wrap));
            end
        end
    end

    initial begin
        // Reset state, then 61 ticks.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_strb = 0;
        cnt_wrap = 0;
        repeat (61) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_time", hrs24() * 3600 + min24() * 60 + sec24(), 61);
        chk("t1_strobe_count", cnt_strb, 61);
        chk("t1_daywrap_count", cnt_wrap, 0);

        // 23:59:58 -> two ticks -> 00:00:00 with one day_wrap.
        preload(23, 59, 58);
        cnt_wrap = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_midnight", hrs24() * 3600 + min24() * 60 + sec24(), 0);
        chk("t2_daywrap_now", int'(a_wrap), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_daywrap_count", cnt_wrap, 1);

        // 12h instance: 12:59:59 tick -> 01:00:00.
        preload(0, 59, 59);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2b_12h_hour", int'(b_ht) * 10 + int'(b_hu), 1);
        chk("t2b_12h_wrap", int'(b_wrap), 1);

        // 60 hour adjusts on the 12h instance return to 12 with no wrap.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_wrap = 0;
        repeat (60) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t3_12h_hour", int'(b_ht) * 10 + int'(b_hu), 12);
        chk("t3_12h_minsec", int'(b_mt) * 10 + int'(b_mu) + int'(b_st) * 10 + int'(b_su), 0);
        chk("t3_wrap_count", cnt_wrap, 0);

        // Adjust beats a coincident tick: 10:59:59 -> 10:59:00.
        preload(10, 59, 59);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t4_time", hrs24() * 3600 + min24() * 60 + sec24(), 10 * 3600 + 59 * 60);
        chk("t4_strobe", int'(a_strb), 1);

        // All three adjusts at once: 05:30:45 -> 06:31:46.
        preload(5, 30, 45);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        chk("t5_time", hrs24() * 3600 + min24() * 60 + sec24(), 6 * 3600 + 31 * 60 + 46);

        // Reset wins over a tick.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_reset_time", hrs24() * 3600 + min24() * 60 + sec24(), 0);
        chk("t6_reset_strobe", int'(a_strb), 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_after_tick", hrs24() * 3600 + min24() * 60 + sec24(), 1);

        // Randomized traffic, including occasional resets and near-rollover preloads.
        for (int i = 0; i < 4000; i++) begin
            if ((i % 800) == 0)
                preload($urandom_range(0, 23), 59, $urandom_range(50, 59));
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        chk("sb_drain", q24.size() + q12.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
